// File: rtl/guitar_pkg.sv
// Shared types and constants for the guitar input path: fret count, strum FSM
// state encoding and the default debounce interval.
package guitar_pkg;

  localparam int unsigned NUM_FRETS            = 7;
  localparam int unsigned DEBOUNCE_CYCLES_DFLT = 250000;  // 5 ms at 50 MHz

  typedef logic [NUM_FRETS-1:0] fret_vec_t;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } strum_state_t;

endpackage : guitar_pkg

// File: rtl/strum_conditioner_if.sv
// Raw guitar controls in, conditioned strum pulses and fret vector out.
// master drives the raw controls; slave is the conditioner.
interface strum_conditioner_if;

  logic                  strum_raw;
  guitar_pkg::fret_vec_t frets_raw;
  logic                  strummerPos;
  logic                  strummerNeg;
  guitar_pkg::fret_vec_t switches;

  modport master (
    output strum_raw,
    output frets_raw,
    input  strummerPos,
    input  strummerNeg,
    input  switches
  );

  modport slave (
    input  strum_raw,
    input  frets_raw,
    output strummerPos,
    output strummerNeg,
    output switches
  );

endinterface : strum_conditioner_if

// File: rtl/sync_2ff.sv
// Parameterised-width two-flop synchroniser for asynchronous level inputs,
// cleared to zero by the asynchronous active-low reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/strum_conditioner.sv
// Synchronises and debounces the strum bar into one-cycle edge pulses and
// conditions the fret switches. Define FRET_DEBOUNCE_EN to debounce the frets too.
module strum_conditioner
  import guitar_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter int unsigned CNT_W           = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  strum_conditioner_if.slave  bus
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic      strum_sync;
  fret_vec_t frets_sync;

  sync_2ff #(.WIDTH(1)) u_strum_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.strum_raw),
    .q_o   (strum_sync)
  );

  sync_2ff #(.WIDTH(NUM_FRETS)) u_fret_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.frets_raw),
    .q_o   (frets_sync)
  );

  // Strum debounce FSM
  strum_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pos_q, pos_d;
  logic             neg_q, neg_d;
  logic             term_c;

  assign term_c = (cnt_q == TERM_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
    end
  end

  // Opposite level during a wait drops back to the idle state it came from
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_LOW:  if (strum_sync)  state_d = WAIT_HIGH;
      WAIT_HIGH: if (!strum_sync) state_d = IDLE_LOW;
                 else if (term_c) state_d = IDLE_HIGH;
      IDLE_HIGH: if (!strum_sync) state_d = WAIT_LOW;
      WAIT_LOW:  if (strum_sync)  state_d = IDLE_HIGH;
                 else if (term_c) state_d = IDLE_LOW;
      default:                    state_d = IDLE_LOW;
    endcase
  end

  // Counter only runs while waiting; idle states hold it at zero
  always_comb begin
    cnt_d = '0;
    pos_d = 1'b0;
    neg_d = 1'b0;
    case (state_q)
      WAIT_HIGH: begin
        if (strum_sync) begin
          if (term_c) pos_d = 1'b1;
          else        cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (!strum_sync) begin
          if (term_c) neg_d = 1'b1;
          else        cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign bus.strummerPos = pos_q;
  assign bus.strummerNeg = neg_q;

`ifdef FRET_DEBOUNCE_EN
  // Candidate vector must stay unchanged for the full interval before loading
  fret_vec_t        sw_q, sw_d;
  fret_vec_t        cand_q, cand_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_q   <= '0;
      cand_q <= '0;
      fcnt_q <= '0;
    end else begin
      sw_q   <= sw_d;
      cand_q <= cand_d;
      fcnt_q <= fcnt_d;
    end
  end

  always_comb begin
    sw_d   = sw_q;
    cand_d = cand_q;
    fcnt_d = fcnt_q;
    if (frets_sync != cand_q) begin
      cand_d = frets_sync;
      fcnt_d = '0;
    end else if (cand_q != sw_q) begin
      if (fcnt_q == TERM_CNT) begin
        sw_d   = cand_q;
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + CNT_W'(1);
      end
    end else begin
      fcnt_d = '0;
    end
  end

  assign bus.switches = sw_q;
`else
  assign bus.switches = frets_sync;
`endif

endmodule : strum_conditioner
